// File: rtl/serial_sync_ctrl_pkg.sv
// Shared definitions for the receive-path link synchronisation controller:
// FSM state encodings, the default comma symbol, counter control bundle and
// a helper that sizes counters from their terminal values.
package serial_sync_ctrl_pkg;

    localparam logic [1:0] ST_LOS  = 2'b00;
    localparam logic [1:0] ST_ACQ  = 2'b01;
    localparam logic [1:0] ST_SYNC = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    localparam logic [7:0] COMMA_SYMBOL = 8'hBC;

    localparam int LOSS_CNT_W = 8;

    // Increment / clear request pair driven into a sat_counter
    typedef struct packed {
        logic inc;
        logic clr;
    } ctr_ctrl_t;

    // Bits needed to hold values 0..max_value, never less than one bit
    function automatic int ctr_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/serial_sync_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_4f,
    input  logic             reset_L,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count register: clear has priority, increment stops at all-ones
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_sync_ctrl.sv
// Byte-rate link synchronisation controller sitting behind the
// serial-to-parallel converter. It hunts for alignment by counting
// consecutive comma bytes, asks the converter to slip a bit while it sees
// no commas, forwards payload bytes once aligned, and falls back to hunting
// after repeated symbol errors.
module serial_sync_ctrl
    import serial_sync_ctrl_pkg::*;
#(
    parameter logic [7:0] COMMA          = COMMA_SYMBOL,
    parameter int         COMMAS_TO_SYNC = 4,
    parameter int         SLIP_TIMEOUT   = 16,
    parameter int         ERRS_TO_LOSE   = 3,
    parameter int         GOOD_TO_CLEAR  = 8
) (
    input  logic                  clk_4f,
    input  logic                  reset_L,
    input  logic [7:0]            data_in,
    input  logic                  data_in_valid,
    input  logic                  symbol_err,
    output logic [7:0]            data_out,
    output logic                  valid_out,
    output logic                  sync_ok,
    output logic                  slip,
    output logic [1:0]            state_out,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    localparam int COMMA_W = ctr_width(COMMAS_TO_SYNC);
    localparam int TMO_W   = ctr_width(SLIP_TIMEOUT - 1);
    localparam int ERR_W   = ctr_width(ERRS_TO_LOSE);
    localparam int GOOD_W  = ctr_width(GOOD_TO_CLEAR);

    // Counter values seen on the byte that completes each threshold
    localparam logic [COMMA_W-1:0] COMMA_LAST = COMMA_W'(COMMAS_TO_SYNC - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(SLIP_TIMEOUT - 1);
    localparam logic [ERR_W-1:0]   ERR_LAST   = ERR_W'(ERRS_TO_LOSE - 1);
    localparam logic [GOOD_W-1:0]  GOOD_LAST  = GOOD_W'(GOOD_TO_CLEAR - 1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [COMMA_W-1:0] comma_cnt;
    logic [COMMA_W-1:0] comma_cnt_nxt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_cnt_nxt;
    logic [ERR_W-1:0]   err_cnt;
    logic [GOOD_W-1:0]  good_cnt;
    logic               slip_nxt;
    logic [7:0]         data_out_nxt;
    logic               valid_out_nxt;
    ctr_ctrl_t          err_ctl;
    ctr_ctrl_t          good_ctl;
    ctr_ctrl_t          loss_ctl;

    logic is_comma;
    logic is_good;

    // An errored comma is treated like any other non-comma byte
    assign is_comma = data_in_valid && (data_in == COMMA) && !symbol_err;
    assign is_good  = data_in_valid && !symbol_err;

    // Aligned whenever the state register sits in SYNC or ERR
    assign sync_ok   = state[1];
    assign state_out = state;

    // Next state, counter updates and slip request; nothing moves on idle cycles
    always_comb begin
        state_nxt     = state;
        comma_cnt_nxt = comma_cnt;
        tmo_cnt_nxt   = tmo_cnt;
        slip_nxt      = 1'b0;
        err_ctl       = '0;
        good_ctl      = '0;
        loss_ctl      = '0;

        if (data_in_valid) begin
            case (state)
                ST_LOS: begin
                    if (is_comma) begin
                        tmo_cnt_nxt = '0;
                        if (COMMAS_TO_SYNC == 1) begin
                            state_nxt     = ST_SYNC;
                            comma_cnt_nxt = '0;
                        end else begin
                            state_nxt     = ST_ACQ;
                            comma_cnt_nxt = COMMA_W'(1);
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        slip_nxt    = 1'b1;
                        tmo_cnt_nxt = '0;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end
                end
                ST_ACQ: begin
                    if (is_comma) begin
                        if (comma_cnt == COMMA_LAST) begin
                            state_nxt     = ST_SYNC;
                            comma_cnt_nxt = '0;
                        end else begin
                            comma_cnt_nxt = comma_cnt + 1'b1;
                        end
                    end else begin
                        state_nxt     = ST_LOS;
                        comma_cnt_nxt = '0;
                        tmo_cnt_nxt   = '0;
                    end
                end
                ST_SYNC: begin
                    if (symbol_err) begin
                        good_ctl.clr = 1'b1;
                        if (ERRS_TO_LOSE == 1) begin
                            state_nxt    = ST_LOS;
                            err_ctl.clr  = 1'b1;
                            loss_ctl.inc = 1'b1;
                        end else begin
                            state_nxt   = ST_ERR;
                            err_ctl.inc = 1'b1;
                        end
                    end
                end
                default: begin
                    if (symbol_err) begin
                        good_ctl.clr = 1'b1;
                        if (err_cnt == ERR_LAST) begin
                            state_nxt    = ST_LOS;
                            err_ctl.clr  = 1'b1;
                            loss_ctl.inc = 1'b1;
                        end else begin
                            err_ctl.inc = 1'b1;
                        end
                    end else if (good_cnt == GOOD_LAST) begin
                        state_nxt    = ST_SYNC;
                        err_ctl.clr  = 1'b1;
                        good_ctl.clr = 1'b1;
                    end else begin
                        good_ctl.inc = 1'b1;
                    end
                end
            endcase
        end
    end

    // Payload gating: clean non-comma bytes pass while aligned, other presented bytes zero the output
    always_comb begin
        data_out_nxt  = data_out;
        valid_out_nxt = 1'b0;
        if (data_in_valid) begin
            if (sync_ok && is_good && (data_in != COMMA)) begin
                data_out_nxt  = data_in;
                valid_out_nxt = 1'b1;
            end else begin
                data_out_nxt = 8'h00;
            end
        end
    end

    // State, acquisition/timeout counters and registered outputs
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= ST_LOS;
            comma_cnt <= '0;
            tmo_cnt   <= '0;
            slip      <= 1'b0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            comma_cnt <= comma_cnt_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            slip      <= slip_nxt;
            data_out  <= data_out_nxt;
            valid_out <= valid_out_nxt;
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .inc     (err_ctl.inc),
        .clr     (err_ctl.clr),
        .count   (err_cnt)
    );

    sat_counter #(.WIDTH(GOOD_W)) u_good_cnt (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .inc     (good_ctl.inc),
        .clr     (good_ctl.clr),
        .count   (good_cnt)
    );

    sat_counter #(.WIDTH(LOSS_CNT_W)) u_loss_cnt (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .inc     (loss_ctl.inc),
        .clr     (loss_ctl.clr),
        .count   (loss_cnt)
    );

endmodule

// File: tb/tb_serial_sync_ctrl.sv
// Self-checking bench for serial_sync_ctrl: a behavioural link model
// tracks what each output must be, a compare process checks it every cycle,
// and directed sequences pin key points with hand-computed values.
module tb_serial_sync_ctrl;

    localparam int P_COMMAS = 4;
    localparam int P_SLIP   = 16;
    localparam int P_ERRS   = 3;
    localparam int P_GOOD   = 8;

    logic       clk_4f        = 1'b0;
    logic       reset_L       = 1'b0;
    logic [7:0] data_in       = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       symbol_err    = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       sync_ok;
    logic       slip;
    logic [1:0] state_out;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model: link phase 0=LOS 1=ACQ 2=SYNC 3=ERR plus run-length tallies
    int         m_phase         = 0;
    int         m_commas_seen   = 0;
    int         m_bytes_no_sync = 0;
    int         m_errs          = 0;
    int         m_goods         = 0;
    int         m_losses        = 0;
    logic       m_slip          = 1'b0;
    logic       m_valid         = 1'b0;
    logic [7:0] m_data          = 8'h00;

    serial_sync_ctrl #(
        .COMMA          (8'hBC),
        .COMMAS_TO_SYNC (P_COMMAS),
        .SLIP_TIMEOUT   (P_SLIP),
        .ERRS_TO_LOSE   (P_ERRS),
        .GOOD_TO_CLEAR  (P_GOOD)
    ) dut (
        .clk_4f        (clk_4f),
        .reset_L       (reset_L),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .symbol_err    (symbol_err),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .sync_ok       (sync_ok),
        .slip          (slip),
        .state_out     (state_out),
        .loss_cnt      (loss_cnt)
    );

    // Byte clock
    always #5 clk_4f = ~clk_4f;

    // Compare one value against its required value and tally the result
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, actual, expected);
        end
    endtask

    // Present one byte (or an idle cycle) and return just after the edge that consumes it
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e);
        data_in_valid = v;
        data_in       = d;
        symbol_err    = e;
        @(posedge clk_4f);
        #1;
    endtask

    // Behavioural link model advanced once per consumed byte
    always @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            m_phase = 0; m_commas_seen = 0; m_bytes_no_sync = 0;
            m_errs = 0; m_goods = 0; m_losses = 0;
            m_slip = 1'b0; m_valid = 1'b0; m_data = 8'h00;
        end else begin
            m_slip  = 1'b0;
            m_valid = 1'b0;
            if (data_in_valid) begin
                if (m_phase >= 2 && !symbol_err && data_in != 8'hBC) begin
                    m_valid = 1'b1;
                    m_data  = data_in;
                end else begin
                    m_data = 8'h00;
                end
                case (m_phase)
                    0: begin
                        if (data_in == 8'hBC && !symbol_err) begin
                            m_bytes_no_sync = 0;
                            m_commas_seen   = 1;
                            m_phase         = (m_commas_seen >= P_COMMAS) ? 2 : 1;
                            if (m_phase == 2) m_commas_seen = 0;
                        end else begin
                            m_bytes_no_sync++;
                            if (m_bytes_no_sync == P_SLIP) begin
                                m_slip          = 1'b1;
                                m_bytes_no_sync = 0;
                            end
                        end
                    end
                    1: begin
                        if (data_in == 8'hBC && !symbol_err) begin
                            m_commas_seen++;
                            if (m_commas_seen == P_COMMAS) begin
                                m_phase       = 2;
                                m_commas_seen = 0;
                            end
                        end else begin
                            m_phase         = 0;
                            m_commas_seen   = 0;
                            m_bytes_no_sync = 0;
                        end
                    end
                    2: begin
                        if (symbol_err) begin
                            m_errs  = 1;
                            m_goods = 0;
                            m_phase = 3;
                            if (m_errs >= P_ERRS) begin
                                m_phase = 0;
                                m_errs  = 0;
                                if (m_losses < 255) m_losses++;
                            end
                        end
                    end
                    default: begin
                        if (symbol_err) begin
                            m_errs++;
                            m_goods = 0;
                            if (m_errs == P_ERRS) begin
                                m_phase = 0;
                                m_errs  = 0;
                                if (m_losses < 255) m_losses++;
                            end
                        end else begin
                            m_goods++;
                            if (m_goods == P_GOOD) begin
                                m_phase = 2;
                                m_errs  = 0;
                                m_goods = 0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge
    always @(negedge clk_4f) begin
        if (cmp_en) begin
            checkOutput("model state_out", 32'(state_out), 32'(m_phase));
            checkOutput("model sync_ok",   32'(sync_ok),   32'(m_phase >= 2));
            checkOutput("model slip",      32'(slip),      32'(m_slip));
            checkOutput("model valid_out", 32'(valid_out), 32'(m_valid));
            checkOutput("model data_out",  32'(data_out),  32'(m_data));
            checkOutput("model loss_cnt",  32'(loss_cnt),  32'(m_losses));
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences with hand-computed expectations
    initial begin
        int slip_pulses;

        repeat (3) @(posedge clk_4f);
        @(negedge clk_4f);
        reset_L = 1'b1;
        cmp_en  = 1'b1;
        #1;

        checkOutput("reset state_out", 32'(state_out), 32'd0);
        checkOutput("reset sync_ok",   32'(sync_ok),   32'd0);
        checkOutput("reset valid_out", 32'(valid_out), 32'd0);
        checkOutput("reset data_out",  32'(data_out),  32'h00);
        checkOutput("reset slip",      32'(slip),      32'd0);
        checkOutput("reset loss_cnt",  32'(loss_cnt),  32'd0);

        // Acquisition: ACQ after first comma, SYNC after fourth
        applyStimulus(1'b1, 8'hBC, 1'b0);
        checkOutput("acq after comma1", 32'(state_out), 32'd1);
        applyStimulus(1'b1, 8'hBC, 1'b0);
        applyStimulus(1'b1, 8'hBC, 1'b0);
        checkOutput("acq after comma3", 32'(state_out), 32'd1);
        applyStimulus(1'b1, 8'hBC, 1'b0);
        checkOutput("sync after comma4",  32'(state_out), 32'd2);
        checkOutput("sync_ok after acq",  32'(sync_ok),   32'd1);
        checkOutput("acq comma not fwd",  32'(valid_out), 32'd0);

        // Payload forwarding in SYNC, commas blanked, idle holds data
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("fwd 5A valid", 32'(valid_out), 32'd1);
        checkOutput("fwd 5A data",  32'(data_out),  32'h5A);
        applyStimulus(1'b1, 8'hBC, 1'b0);
        checkOutput("fwd BC valid", 32'(valid_out), 32'd0);
        checkOutput("fwd BC data",  32'(data_out),  32'h00);
        applyStimulus(1'b1, 8'hC3, 1'b0);
        checkOutput("fwd C3 valid", 32'(valid_out), 32'd1);
        checkOutput("fwd C3 data",  32'(data_out),  32'hC3);
        applyStimulus(1'b0, 8'h99, 1'b0);
        checkOutput("idle valid",     32'(valid_out), 32'd0);
        checkOutput("idle data hold", 32'(data_out),  32'hC3);

        // Three symbol errors: SYNC -> ERR -> LOS, one loss counted
        applyStimulus(1'b1, 8'h11, 1'b1);
        checkOutput("err1 state", 32'(state_out), 32'd3);
        checkOutput("err1 valid", 32'(valid_out), 32'd0);
        applyStimulus(1'b1, 8'h11, 1'b1);
        applyStimulus(1'b1, 8'h11, 1'b1);
        checkOutput("err3 state",    32'(state_out), 32'd0);
        checkOutput("err3 loss_cnt", 32'(loss_cnt),  32'd1);
        checkOutput("err3 sync_ok",  32'(sync_ok),   32'd0);

        // Slip timeout in LOS: pulses after the 16th and 32nd valid byte, idle cycle ignored
        slip_pulses = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            checkOutput("slip position", 32'(slip), 32'((i == 15) || (i == 31)));
            if (slip) slip_pulses++;
            if (i == 7) begin
                applyStimulus(1'b0, 8'h00, 1'b0);
                checkOutput("slip idle", 32'(slip), 32'd0);
            end
        end
        checkOutput("slip pulse count", 32'(slip_pulses), 32'd2);

        // Broken comma run in ACQ returns to LOS without a loss
        applyStimulus(1'b1, 8'hBC, 1'b0);
        applyStimulus(1'b1, 8'hBC, 1'b0);
        applyStimulus(1'b1, 8'hBC, 1'b0);
        checkOutput("acq3 state", 32'(state_out), 32'd1);
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("acq break state", 32'(state_out), 32'd0);
        checkOutput("acq break loss",  32'(loss_cnt),  32'd1);

        // Errored comma counts as a non-comma
        applyStimulus(1'b1, 8'hBC, 1'b0);
        applyStimulus(1'b1, 8'hBC, 1'b0);
        applyStimulus(1'b1, 8'hBC, 1'b1);
        checkOutput("errored comma state", 32'(state_out), 32'd0);

        // Four fresh commas required
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hBC, 1'b0);
        checkOutput("reacq state", 32'(state_out), 32'd2);

        // One error, then eight good bytes clear back to SYNC; the eighth is forwarded
        applyStimulus(1'b1, 8'h22, 1'b1);
        checkOutput("alt err state", 32'(state_out), 32'd3);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0);
            checkOutput("alt good still err", 32'(state_out), 32'd3);
        end
        applyStimulus(1'b1, 8'h47, 1'b0);
        checkOutput("alt clear state", 32'(state_out), 32'd2);
        checkOutput("alt clear valid", 32'(valid_out), 32'd1);
        checkOutput("alt clear data",  32'(data_out),  32'h47);

        // Error count was cleared: two more errors leave the link in ERR
        applyStimulus(1'b1, 8'h33, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b1);
        checkOutput("err cleared state", 32'(state_out), 32'd3);
        checkOutput("err cleared loss",  32'(loss_cnt),  32'd1);

        // Asynchronous reset while in ERR with a good byte on the input
        applyStimulus(1'b1, 8'h77, 1'b0);
        checkOutput("pre-reset valid", 32'(valid_out), 32'd1);
        #2;
        reset_L = 1'b0;
        #1;
        checkOutput("async rst state", 32'(state_out), 32'd0);
        checkOutput("async rst valid", 32'(valid_out), 32'd0);
        checkOutput("async rst data",  32'(data_out),  32'h00);
        checkOutput("async rst sync",  32'(sync_ok),   32'd0);
        checkOutput("async rst slip",  32'(slip),      32'd0);
        checkOutput("async rst loss",  32'(loss_cnt),  32'd0);
        @(posedge clk_4f);
        #1;
        checkOutput("held rst valid", 32'(valid_out), 32'd0);
        @(negedge clk_4f);
        reset_L = 1'b1;

        // Loss counter saturation: 255 losses, then one more
        for (int k = 0; k < 255; k++) begin
            for (int c = 0; c < 4; c++) applyStimulus(1'b1, 8'hBC, 1'b0);
            for (int e = 0; e < 3; e++) applyStimulus(1'b1, 8'h55, 1'b1);
        end
        checkOutput("loss 255", 32'(loss_cnt), 32'd255);
        for (int c = 0; c < 4; c++) applyStimulus(1'b1, 8'hBC, 1'b0);
        for (int e = 0; e < 3; e++) applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("loss saturated", 32'(loss_cnt),  32'd255);
        checkOutput("loss sat state", 32'(state_out), 32'd0);

        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk_4f);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
